alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum cycles in WAIT without ALU_ready before an error is flagged.
REQ-002 SHALL have port soc_clk  in  1  the only clock; all logic on the rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  in  1  decoded operation offered.
REQ-005 SHALL have port issue_ready  out  1  controller accepts an operation this cycle.
REQ-006 SHALL have port issue_op  in  5  ALU operation code; 0-5 branch, 6-15 I/R, 16-31 illegal.
REQ-007 SHALL have port issue_rs1 / issue_rs2  in  32 each  operand values.
REQ-008 SHALL have port issue_rd  in  5  destination register index.
REQ-009 SHALL have ports ALU_dat1 / ALU_dat2  out  32 each  operands to the ALU.
REQ-010 SHALL have port Instruction_to_ALU  out  5  operation code to the ALU.
REQ-011 SHALL have port dat_ready  out  1  ALU enable; held high for the whole operation.
REQ-012 SHALL have ports ALU_out  in  32 and ALU_ready, ALU_overflow, ALU_zero, ALU_con_met  in  1 each  ALU results.
REQ-013 SHALL have ports wb_valid  out  1, wb_rd  out  5, wb_data  out  32  register writeback.
REQ-014 SHALL have ports wb_ovf and wb_zero  out  1 each  flags accompanying writeback.
REQ-015 SHALL have ports br_valid and br_taken  out  1 each  branch resolution.
REQ-016 SHALL have port op_err  out  1  one-cycle error pulse.

Function
REQ-017 SHALL implement states IDLE, WAIT, DRAIN; issue_ready = 1 only in IDLE.
REQ-018 IDLE with issue_valid=1 and issue_op<=15 SHALL, at the accepting edge, register rs1, rs2, op and rd onto ALU_dat1, ALU_dat2, Instruction_to_ALU and an internal rd, set dat_ready=1, clear the wait counter, and enter WAIT.
REQ-019 IDLE with issue_valid=1 and issue_op>=16 SHALL pulse op_err for one cycle, keep dat_ready=0, and remain in IDLE.
REQ-020 ALU_dat1, ALU_dat2 and Instruction_to_ALU SHALL hold stable from acceptance until re-entry to IDLE.
REQ-021 In WAIT, on the first edge with ALU_ready=1, the controller SHALL sample ALU_out and flags, drive dat_ready=0, and enter DRAIN.
REQ-022 For ops 6-15 with rd != 0, the controller SHALL pulse wb_valid for exactly one cycle in DRAIN, with wb_rd = rd, wb_data = sampled ALU_out, and wb_ovf / wb_zero = the sampled flags.
REQ-023 For ops 6-15 with rd = 0, the controller SHALL suppress wb_valid; the operation otherwise completes normally.
REQ-024 For ops 0-5, the controller SHALL pulse br_valid for one cycle in DRAIN with br_taken = sampled ALU_con_met, and SHALL NOT assert wb_valid.
REQ-025 In WAIT, the wait counter SHALL increment each cycle ALU_ready=0; on reaching TIMEOUT it SHALL pulse op_err, drive dat_ready=0, and enter DRAIN with no wb or br pulse.
REQ-026 If ALU_ready=1 on the same cycle the counter reaches TIMEOUT, completion SHALL win and op_err SHALL stay 0.
REQ-027 DRAIN SHALL last exactly one cycle with dat_ready=0, then return to IDLE; minimum accept-to-accept spacing is therefore 3 cycles plus ALU latency.
REQ-028 wb_data, wb_rd, wb_ovf and wb_zero SHALL hold their last values when wb_valid=0; br_taken SHALL be 0 whenever br_valid=0.
REQ-029 issue_valid asserted outside IDLE SHALL be ignored; no operand is captured.

Reset
REQ-030 Reset SHALL force, at the next edge, state IDLE; dat_ready, wb_valid, br_valid, br_taken, op_err, wb_ovf and wb_zero = 0; ALU_dat1, ALU_dat2, wb_data = 0; Instruction_to_ALU, wb_rd = 0; wait counter = 0.
REQ-031 Reset SHALL take priority over every other event, including mid-WAIT: the in-flight operation is discarded with no wb, br or err pulse.
REQ-032 issue_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 ADD: op=6, rs1=5, rs2=7, rd=3 -> dat_ready high until ALU_ready; one wb_valid pulse with wb_rd=3, wb_data=12, wb_zero=0.
REQ-034 BEQ: op=0, rs1=rs2=9 -> br_valid pulse with br_taken=1 and no wb_valid; repeat with rs2=8 -> br_taken=0.
REQ-035 Illegal op: op=20 -> op_err pulse for 1 cycle; dat_ready stays 0; issue_ready=1 on the next cycle.
REQ-036 Timeout: op=6 with ALU_ready tied 0 -> op_err after 8 WAIT cycles, dat_ready falls, no wb; a simultaneous ALU_ready on the 8th cycle produces wb_valid with no op_err.
REQ-037 rd=0: op=11 (XOR), rs1=0xFFFF0000, rs2=0x0000FFFF, rd=0 -> no wb_valid; controller returns to IDLE.
REQ-038 Reset asserted 2 cycles into WAIT -> next edge dat_ready=0 and issue_ready=1 after deassertion; no pulses observed.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded operation at a time to an external ALU.
// It holds the operands and enable until the ALU reports ready or the wait times
// out. It then spends one drain cycle presenting either a register writeback or a
// branch resolution.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready to accept; illegal ops (>=16) get an op_err pulse here
// WAIT  | operands and dat_ready held on the ALU; counting cycles without ready
// DRAIN | single cycle carrying the wb/br/err pulse, then back to IDLE
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_op,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [4:0]  Instruction_to_ALU,
  output logic        dat_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_ready,
  input  logic        ALU_overflow,
  input  logic        ALU_zero,
  input  logic        ALU_con_met,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_ovf,
  output logic        wb_zero,
  output logic        br_valid,
  output logic        br_taken,
  output logic        op_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       op_rd;
  logic             accept;
  logic             illegal;
  logic             complete;
  logic             expire;
  logic             is_branch;
  logic             do_wb;

  assign issue_ready = (state == S_IDLE);
  assign is_branch   = (Instruction_to_ALU <= 5'd5);
  // Writeback is skipped for branches and for the hard-wired zero register.
  assign do_wb       = complete && !is_branch && (op_rd != 5'd0);

  // Next-state decode and the per-cycle event strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    illegal    = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue_valid) begin
          if (!issue_op[4]) begin
            accept     = 1'b1;
            state_next = S_WAIT;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A ready arriving on the last counted cycle still counts as completion.
        if (ALU_ready) begin
          complete   = 1'b1;
          state_next = S_DRAIN;
        end else if (wait_cnt == CNT_LAST) begin
          expire     = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, wait counter and the registered result/pulse outputs.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      ALU_dat1           <= '0;
      ALU_dat2           <= '0;
      Instruction_to_ALU <= '0;
      op_rd              <= '0;
      dat_ready          <= 1'b0;
      wait_cnt           <= '0;
      wb_valid           <= 1'b0;
      wb_rd              <= '0;
      wb_data            <= '0;
      wb_ovf             <= 1'b0;
      wb_zero            <= 1'b0;
      br_valid           <= 1'b0;
      br_taken           <= 1'b0;
      op_err             <= 1'b0;
    end else begin
      op_err   <= illegal | expire;
      wb_valid <= do_wb;
      br_valid <= complete && is_branch;
      br_taken <= complete && is_branch && ALU_con_met;

      if (accept) begin
        ALU_dat1           <= issue_rs1;
        ALU_dat2           <= issue_rs2;
        Instruction_to_ALU <= issue_op;
        op_rd              <= issue_rd;
        dat_ready          <= 1'b1;
        wait_cnt           <= '0;
      end else if (state == S_WAIT && !ALU_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (complete || expire) begin
        dat_ready <= 1'b0;
      end

      // Writeback fields only move when a writeback is actually presented.
      if (do_wb) begin
        wb_rd   <= op_rd;
        wb_data <= ALU_out;
        wb_ovf  <= ALU_overflow;
        wb_zero <= ALU_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: add, branches, illegal op, timeout
// boundary, rd=0 suppression and reset in the middle of WAIT.
module tb_alu_issue_ctrl;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_op;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd;
  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [4:0]  Instruction_to_ALU;
  logic        dat_ready;
  logic [31:0] ALU_out;
  logic        ALU_ready;
  logic        ALU_overflow;
  logic        ALU_zero;
  logic        ALU_con_met;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ovf;
  logic        wb_zero;
  logic        br_valid;
  logic        br_taken;
  logic        op_err;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.TIMEOUT(8)) dut (
    .soc_clk            (soc_clk),
    .reset              (reset),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_op           (issue_op),
    .issue_rs1          (issue_rs1),
    .issue_rs2          (issue_rs2),
    .issue_rd           (issue_rd),
    .ALU_dat1           (ALU_dat1),
    .ALU_dat2           (ALU_dat2),
    .Instruction_to_ALU (Instruction_to_ALU),
    .dat_ready          (dat_ready),
    .ALU_out            (ALU_out),
    .ALU_ready          (ALU_ready),
    .ALU_overflow       (ALU_overflow),
    .ALU_zero           (ALU_zero),
    .ALU_con_met        (ALU_con_met),
    .wb_valid           (wb_valid),
    .wb_rd              (wb_rd),
    .wb_data            (wb_data),
    .wb_ovf             (wb_ovf),
    .wb_zero            (wb_zero),
    .br_valid           (br_valid),
    .br_taken           (br_taken),
    .op_err             (op_err)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_rd    = rd;
  endtask

  task automatic alu_resp(input logic rdy, input logic [31:0] res, input logic ovf,
                          input logic zero, input logic con);
    ALU_ready    = rdy;
    ALU_out      = res;
    ALU_overflow = ovf;
    ALU_zero     = zero;
    ALU_con_met  = con;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_rd = '0;
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_dat_ready", {31'b0, dat_ready}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_op_err", {31'b0, op_err}, 32'd0);
    chk("rst_br", {30'b0, br_valid, br_taken}, 32'd0);
    chk("rst_dat1", ALU_dat1, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_instr_wbrd", {22'b0, Instruction_to_ALU, wb_rd}, 32'd0);
    reset = 1'b0;
    chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);

    // ADD 5+7 -> x3
    offer(5'd6, 32'd5, 32'd7, 5'd3);
    tick();
    chk("add_dat_ready", {31'b0, dat_ready}, 32'd1);
    chk("add_issue_ready", {31'b0, issue_ready}, 32'd0);
    chk("add_dat1", ALU_dat1, 32'd5);
    chk("add_dat2", ALU_dat2, 32'd7);
    chk("add_instr", {27'b0, Instruction_to_ALU}, 32'd6);
    // offer outside IDLE must be ignored
    offer(5'd7, 32'hAAAA, 32'hBBBB, 5'd9);
    tick();
    chk("add_hold_dat_ready", {31'b0, dat_ready}, 32'd1);
    chk("add_ignore_dat1", ALU_dat1, 32'd5);
    chk("add_ignore_instr", {27'b0, Instruction_to_ALU}, 32'd6);
    issue_valid = 1'b0;
    alu_resp(1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    tick();
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("add_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("add_wb_rd", {27'b0, wb_rd}, 32'd3);
    chk("add_wb_data", wb_data, 32'd12);
    chk("add_wb_zero", {31'b0, wb_zero}, 32'd0);
    chk("add_drain_dat_ready", {31'b0, dat_ready}, 32'd0);
    chk("add_drain_br", {31'b0, br_valid}, 32'd0);
    tick();
    chk("add_wb_pulse_end", {31'b0, wb_valid}, 32'd0);
    chk("add_wb_data_hold", wb_data, 32'd12);
    chk("add_idle", {31'b0, issue_ready}, 32'd1);

    // BEQ taken
    offer(5'd0, 32'd9, 32'd9, 5'd5);
    tick();
    issue_valid = 1'b0;
    alu_resp(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
    tick();
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("beq_t_br_valid", {31'b0, br_valid}, 32'd1);
    chk("beq_t_br_taken", {31'b0, br_taken}, 32'd1);
    chk("beq_t_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("beq_t_wb_data_hold", wb_data, 32'd12);
    tick();
    chk("beq_t_br_end", {30'b0, br_valid, br_taken}, 32'd0);

    // BEQ not taken
    offer(5'd0, 32'd9, 32'd8, 5'd5);
    tick();
    issue_valid = 1'b0;
    alu_resp(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("beq_nt_br", {30'b0, br_valid, br_taken}, 32'b10);
    chk("beq_nt_no_wb", {31'b0, wb_valid}, 32'd0);
    tick();

    // Illegal op
    offer(5'd20, 32'd1, 32'd2, 5'd1);
    tick();
    issue_valid = 1'b0;
    chk("ill_op_err", {31'b0, op_err}, 32'd1);
    chk("ill_dat_ready", {31'b0, dat_ready}, 32'd0);
    chk("ill_issue_ready", {31'b0, issue_ready}, 32'd1);
    tick();
    chk("ill_op_err_end", {31'b0, op_err}, 32'd0);

    // Timeout: 8 WAIT cycles with no ready
    offer(5'd6, 32'd1, 32'd2, 5'd4);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("to_pre_op_err", {31'b0, op_err}, 32'd0);
    chk("to_pre_dat_ready", {31'b0, dat_ready}, 32'd1);
    tick();
    chk("to_op_err", {31'b0, op_err}, 32'd1);
    chk("to_dat_ready", {31'b0, dat_ready}, 32'd0);
    chk("to_no_wb", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("to_op_err_end", {31'b0, op_err}, 32'd0);
    chk("to_idle", {31'b0, issue_ready}, 32'd1);

    // Ready on the 8th WAIT cycle beats the timeout
    offer(5'd6, 32'd1, 32'd2, 5'd4);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    alu_resp(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    tick();
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("race_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("race_no_op_err", {31'b0, op_err}, 32'd0);
    chk("race_wb_data", wb_data, 32'h55);
    chk("race_wb_ovf_rd", {26'b0, wb_ovf, wb_rd}, {26'b0, 1'b1, 5'd4});
    tick();

    // XOR to rd=0: no writeback
    offer(5'd11, 32'hFFFF0000, 32'h0000FFFF, 5'd0);
    tick();
    issue_valid = 1'b0;
    chk("xor_dat1", ALU_dat1, 32'hFFFF0000);
    alu_resp(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("xor_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("xor_wb_data_hold", wb_data, 32'h55);
    chk("xor_dat_ready", {31'b0, dat_ready}, 32'd0);
    tick();
    chk("xor_idle", {31'b0, issue_ready}, 32'd1);

    // Reset two cycles into WAIT, with ALU_ready racing the reset
    offer(5'd6, 32'd3, 32'd4, 5'd7);
    tick();
    issue_valid = 1'b0;
    tick();
    reset = 1'b1;
    alu_resp(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mrst_dat_ready", {31'b0, dat_ready}, 32'd0);
    chk("mrst_pulses", {29'b0, wb_valid, br_valid, op_err}, 32'd0);
    chk("mrst_dat1", ALU_dat1, 32'd0);
    chk("mrst_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    alu_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mrst_issue_ready", {31'b0, issue_ready}, 32'd1);
    tick();
    chk("mrst_after_pulses", {29'b0, wb_valid, br_valid, op_err}, 32'd0);
    chk("mrst_after_ready", {31'b0, issue_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
